mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Bus-responder end of the CPU byte memory interface: the CPU drives address, write data and write strobe, and this block answers.
- Provides 128 KB byte RAM with 1-cycle read latency.
- Decodes the I/O window (addr[17:16]==2'b11): UART TX FIFO with io_buffer_full back-pressure, UART RX holding byte, free-running cycle counter, program-stop flag.
- Sits at top level between the cpu instance and the UART/host interface.

Parameters:
RAM_ADDR_WIDTH, 17, byte address bits of RAM (2^17 = 128 KB)
TX_FIFO_DEPTH_LOG2, 4, log2 of TX FIFO entries (16)
FULL_MARGIN, 2, free-entry threshold at or below which io_buffer_full asserts

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  ready; bus accesses and counter frozen when low
cpu_a  input  32  CPU address; only [17:0] decoded
cpu_dout  input  8  CPU write data
cpu_wr  input  1  1 = write, 0 = read
cpu_din  output  8  read data to CPU, registered
io_buffer_full  output  1  TX FIFO nearly full
uart_tx_data  output  8  FIFO head byte
uart_tx_valid  output  1  FIFO non-empty
uart_tx_ready  input  1  UART accepts head byte this cycle
uart_rx_data  input  8  received byte
uart_rx_valid  input  1  1-cycle pulse, rx byte present
program_stop  output  1  sticky halt indication

Behaviour:
- Clocking and reset:
  - One clock, clk_in.
  - rst_n_in is asynchronous and active-low.
  - On reset: cpu_din=0, io_buffer_full=0, uart_tx_valid=0, uart_tx_data=0, program_stop=0; FIFO empty, counter=0, snapshot=0, rx holding empty.
  - RAM contents are not reset.
- Decode:
  - io = (cpu_a[17:16]==2'b11).
  - RAM index = cpu_a[RAM_ADDR_WIDTH-1:0].
  - Non-io addresses with bit 17 set alias into RAM.
- All bus actions below occur only when rdy_in=1. When rdy_in=0, the CPU side has no state change and cpu_din holds its value.
- RAM write: cpu_wr=1 and !io -> ram[index] <= cpu_dout at this edge.
- RAM read: cpu_wr=0 and !io -> cpu_din <= ram[index] at this edge.
  - Data is visible the cycle after the address (1-cycle latency).
  - A read of the address written in the previous cycle returns the new data.
- IO read, low 3 bits of address:
  - 0 -> cpu_din <= rx byte if holding full, else 0x00; holding cleared on that read.
  - 4 -> cpu_din <= counter[7:0]; snapshot <= counter.
  - 5/6/7 -> cpu_din <= snapshot[15:8]/[23:16]/[31:24], giving a coherent dword.
  - Other -> 0x00.
- RX holding register:
  - uart_rx_valid loads the holding register and sets it full; a newer byte overwrites an unread one.
  - If rx_valid arrives in the same cycle as a read of 0x30000, the read returns the old contents (or 0x00 if empty) and the new byte stays held.
- IO write, low 3 bits of address:
  - 0 -> push cpu_dout if nonzero; 0x00 is ignored.
  - 4 -> program_stop <= 1 (sticky until reset) and push 0x00.
  - Others ignored.
- TX FIFO:
  - Circular buffer with TX_FIFO_DEPTH_LOG2+1-bit read/write pointers; wrap at depth.
  - uart_tx_valid = !empty; uart_tx_data = head.
  - Pop on uart_tx_valid & uart_tx_ready, regardless of rdy_in.
  - Push and pop in the same cycle: count unchanged, both accepted even when full.
  - Push while full with no pop: byte dropped.
- io_buffer_full:
  - Registered; 1 when free entries after this cycle's push/pop <= FULL_MARGIN, else 0.
  - The margin covers the CPU's 1-cycle reaction latency.
- Counter:
  - 32-bit; +1 each cycle with rdy_in=1 and program_stop=0.
  - Wraps 0xFFFFFFFF -> 0; frozen once program_stop is set.
- Reset mid-operation: FIFO contents discarded, a pending read returns 0, no partial pushes.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> cpu_din=0xA5 one cycle after the read address; a write to 0x1FFFF followed by a read of 0x1FFFF returns the written byte.
- Write 0x41, 0x00, 0x42 to 0x30000 with uart_tx_ready=1 -> uart_tx_data sequence 0x41, 0x42 only.
- uart_tx_ready=0, 14 nonzero writes to 0x30000 -> io_buffer_full=1 the cycle after the 14th push; 3 more writes -> 16 entries stored, 17th dropped; ready=1 drains exactly 16 bytes in order.
- Run 300 cycles, read 0x30004..0x30007 on consecutive cycles -> bytes equal to the counter value latched at the 0x30004 read, little-endian, unchanged by later increments.
- uart_rx_valid with 0x5A, read 0x30000 twice -> 0x5A then 0x00.
- Write to 0x30004 -> program_stop=1 next cycle, 0x00 appears on uart_tx_data, counter frozen; rdy_in=0 during a RAM write -> RAM unchanged; rst_n_in low mid-drain -> uart_tx_valid=0 immediately (async).

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU byte-bus interface between the CPU and mem_io_responder.
//   cpu_a          : CPU address (only [17:0] decoded by the responder)
//   cpu_dout       : CPU write data
//   cpu_wr         : 1 = write, 0 = read
//   cpu_din        : registered read data back to the CPU
//   io_buffer_full : TX FIFO nearly-full back-pressure to the CPU
// master = CPU side, slave = responder side.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;

    modport master (
        output cpu_a, cpu_dout, cpu_wr,
        input  cpu_din, io_buffer_full
    );

    modport slave (
        input  cpu_a, cpu_dout, cpu_wr,
        output cpu_din, io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Bus responder for the CPU byte memory interface.
// Provides a byte RAM (1-cycle read latency) and an I/O window at
// addr[17:16]==2'b11 with a UART TX FIFO, a UART RX holding byte, a free
// running cycle counter with a coherent 32-bit snapshot, and a sticky
// program-stop flag.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   rdy_in           : bus accesses and counter frozen when low
//   bus              : CPU bus (slave modport of mem_io_responder_if)
//   uart_tx_*        : FIFO head byte / non-empty / UART accept
//   uart_rx_*        : received byte with 1-cycle valid pulse
//   program_stop     : sticky halt indication
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH     = 17,
    parameter int TX_FIFO_DEPTH_LOG2 = 4,
    parameter int FULL_MARGIN        = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    mem_io_responder_if.slave         bus,
    output logic [7:0]                uart_tx_data,
    output logic                      uart_tx_valid,
    input  logic                      uart_tx_ready,
    input  logic [7:0]                uart_rx_data,
    input  logic                      uart_rx_valid,
    output logic                      program_stop
);

    localparam int DEPTH = 1 << TX_FIFO_DEPTH_LOG2;
    localparam int PW    = TX_FIFO_DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL_THRESH = PW'(DEPTH - FULL_MARGIN);
    localparam logic [PW-1:0] DEPTH_CNT   = PW'(DEPTH);

    logic [7:0] ram_mem  [0:(2**RAM_ADDR_WIDTH)-1];
    logic [7:0] fifo_mem [0:DEPTH-1];

    logic [7:0]    cpu_din_q, cpu_din_d;
    logic          io_buffer_full_q, io_buffer_full_d;
    logic          program_stop_q, program_stop_d;
    logic [31:0]   counter_q, counter_d;
    logic [31:0]   snapshot_q, snapshot_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_full_q, rx_full_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic                      is_io;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [2:0]                io_sel;
    logic                      ram_we;
    logic [PW-1:0]             count, count_next;
    logic                      fifo_empty, fifo_full;
    logic                      push_req, push, pop;
    logic [7:0]                push_data;
    logic                      rx_read;
    logic                      unused_addr_hi;

    assign unused_addr_hi = ^bus.cpu_a[31:18];

    always_comb begin
        is_io      = (bus.cpu_a[17:16] == 2'b11);
        ram_idx    = bus.cpu_a[RAM_ADDR_WIDTH-1:0];
        io_sel     = bus.cpu_a[2:0];
        ram_we     = rdy_in && bus.cpu_wr && !is_io;

        count      = wr_ptr_q - rd_ptr_q;
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_CNT);
        pop        = !fifo_empty && uart_tx_ready;

        // 0x00 writes to the data port are swallowed; the stop port pushes 0x00
        push_req   = rdy_in && is_io && bus.cpu_wr &&
                     (((io_sel == 3'd0) && (bus.cpu_dout != 8'h00)) || (io_sel == 3'd4));
        push_data  = (io_sel == 3'd4) ? 8'h00 : bus.cpu_dout;
        // a simultaneous pop frees the slot, so a full FIFO still accepts
        push       = push_req && (!fifo_full || pop);

        rx_read    = rdy_in && is_io && !bus.cpu_wr && (io_sel == 3'd0);
    end

    always_comb begin
        cpu_din_d      = cpu_din_q;
        snapshot_d     = snapshot_q;
        program_stop_d = program_stop_q;
        counter_d      = counter_q;
        rx_data_d      = rx_data_q;
        rx_full_d      = rx_full_q;

        if (rdy_in) begin
            if (!bus.cpu_wr) begin
                if (!is_io) begin
                    cpu_din_d = ram_mem[ram_idx];
                end else begin
                    case (io_sel)
                        3'd0: cpu_din_d = rx_full_q ? rx_data_q : 8'h00;
                        3'd4: begin
                            cpu_din_d  = counter_q[7:0];
                            snapshot_d = counter_q;
                        end
                        3'd5: cpu_din_d = snapshot_q[15:8];
                        3'd6: cpu_din_d = snapshot_q[23:16];
                        3'd7: cpu_din_d = snapshot_q[31:24];
                        default: cpu_din_d = 8'h00;
                    endcase
                end
            end else if (is_io && (io_sel == 3'd4)) begin
                program_stop_d = 1'b1;
            end
            if (!program_stop_q) begin
                counter_d = counter_q + 32'd1;
            end
        end

        // a byte arriving alongside the read wins: the read saw the old value
        if (rx_read) begin
            rx_full_d = 1'b0;
        end
        if (uart_rx_valid) begin
            rx_data_d = uart_rx_data;
            rx_full_d = 1'b1;
        end

        wr_ptr_d         = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d         = rd_ptr_q + {{(PW-1){1'b0}}, pop};
        count_next       = wr_ptr_d - rd_ptr_d;
        io_buffer_full_d = (count_next >= FULL_THRESH);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cpu_din_q        <= '0;
            io_buffer_full_q <= 1'b0;
            program_stop_q   <= 1'b0;
            counter_q        <= '0;
            snapshot_q       <= '0;
            rx_data_q        <= '0;
            rx_full_q        <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
        end else begin
            cpu_din_q        <= cpu_din_d;
            io_buffer_full_q <= io_buffer_full_d;
            program_stop_q   <= program_stop_d;
            counter_q        <= counter_d;
            snapshot_q       <= snapshot_d;
            rx_data_q        <= rx_data_d;
            rx_full_q        <= rx_full_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
        end
    end

    // storage arrays are not reset
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= bus.cpu_dout;
        end
        if (push) begin
            fifo_mem[wr_ptr_q[TX_FIFO_DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    assign bus.cpu_din        = cpu_din_q;
    assign bus.io_buffer_full = io_buffer_full_q;
    assign program_stop       = program_stop_q;
    assign uart_tx_valid      = !fifo_empty;
    // mask the unreset storage so the head reads 0 while empty
    assign uart_tx_data       = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[TX_FIFO_DEPTH_LOG2-1:0]];

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: stimulus pushes expected read data
// and expected TX bytes into queues; negedge monitors pop and compare.
module tb_mem_io_responder;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       rdy_in;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       program_stop;

    mem_io_responder_if bus_if ();

    mem_io_responder #(
        .RAM_ADDR_WIDTH    (17),
        .TX_FIFO_DEPTH_LOG2(4),
        .FULL_MARGIN       (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .bus          (bus_if),
        .uart_tx_data (uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .program_stop (program_stop)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    byte unsigned rd_q[$];
    string        rd_name_q[$];
    byte unsigned tx_q[$];

    logic        rd_now = 1'b0;
    logic        rd_seen;
    logic [31:0] m_cnt;
    logic        m_stop;
    logic [31:0] snap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference cycle counter driven only by bench stimulus
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_cnt  <= '0;
            m_stop <= 1'b0;
        end else if (rdy_in) begin
            if (!m_stop) m_cnt <= m_cnt + 32'd1;
            if (bus_if.cpu_wr && bus_if.cpu_a[17:0] == 18'h30004) m_stop <= 1'b1;
        end
    end

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rd_seen <= 1'b0;
        else           rd_seen <= rd_now && rdy_in;
    end

    // monitors
    always @(negedge clk_in) begin
        byte unsigned e;
        string n;
        if (rst_n_in) begin
            if (rd_seen) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: got 0x%0h expected none", bus_if.cpu_din);
                end else begin
                    e = rd_q.pop_front();
                    n = rd_name_q.pop_front();
                    chk(n, {24'h0, bus_if.cpu_din}, {24'h0, e});
                end
            end
            if (uart_tx_valid && uart_tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected: got 0x%0h expected none", uart_tx_data);
                end else begin
                    e = tx_q.pop_front();
                    chk("tx_byte", {24'h0, uart_tx_data}, {24'h0, e});
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus_if.cpu_a    = 32'h0;
        bus_if.cpu_wr   = 1'b0;
        bus_if.cpu_dout = 8'h00;
        rd_now          = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d);
        bus_if.cpu_a    = a;
        bus_if.cpu_dout = d;
        bus_if.cpu_wr   = 1'b1;
        rd_now          = 1'b0;
        cycle();
        idle();
    endtask

    task automatic do_read(input logic [31:0] a, input byte unsigned exp, input string name);
        bus_if.cpu_a  = a;
        bus_if.cpu_wr = 1'b0;
        rd_now        = 1'b1;
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        cycle();
        idle();
    endtask

    task automatic tx_write(input byte unsigned d);
        do_write(32'h30000, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;
        idle();
        repeat (3) cycle();

        chk("rst_cpu_din",   {24'h0, bus_if.cpu_din}, 32'h0);
        chk("rst_buf_full",  {31'h0, bus_if.io_buffer_full}, 32'h0);
        chk("rst_tx_valid",  {31'h0, uart_tx_valid}, 32'h0);
        chk("rst_tx_data",   {24'h0, uart_tx_data}, 32'h0);
        chk("rst_prog_stop", {31'h0, program_stop}, 32'h0);
        rst_n_in = 1'b1;
        cycle();

        // RAM write/read, top address, bit-17 alias, bit-16 distinct
        do_write(32'h00010, 8'hA5);
        do_read (32'h00010, 8'hA5, "ram_rd_10");
        do_write(32'h1FFFF, 8'h3C);
        do_read (32'h1FFFF, 8'h3C, "ram_rd_1ffff");
        do_write(32'h10010, 8'h77);
        do_read (32'h20010, 8'hA5, "ram_alias_20010");
        do_read (32'h10010, 8'h77, "ram_rd_10010");
        do_read (32'h00010, 8'hA5, "ram_rd_10_again");

        // cpu_din holds and RAM is untouched while rdy_in is low
        rdy_in = 1'b0;
        bus_if.cpu_a = 32'h1FFFF;
        cycle();
        chk("rdy0_din_hold", {24'h0, bus_if.cpu_din}, 32'hA5);
        bus_if.cpu_a    = 32'h00010;
        bus_if.cpu_dout = 8'hEE;
        bus_if.cpu_wr   = 1'b1;
        cycle();
        idle();
        rdy_in = 1'b1;
        do_read(32'h00010, 8'hA5, "rdy0_ram_unchanged");

        // TX: zero byte is swallowed
        uart_tx_ready = 1'b1;
        tx_q.push_back(8'h41); tx_write(8'h41);
        tx_write(8'h00);
        tx_q.push_back(8'h42); tx_write(8'h42);
        repeat (4) cycle();
        chk("tx_zero_skip_empty", {31'h0, uart_tx_valid}, 32'h0);

        // fill with back-pressure; full flag after the 14th push
        uart_tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tx_q.push_back(byte'(i));
            tx_write(byte'(i));
            if (i == 13) chk("buf_full_at_13", {31'h0, bus_if.io_buffer_full}, 32'h0);
        end
        chk("buf_full_at_14", {31'h0, bus_if.io_buffer_full}, 32'h1);
        tx_q.push_back(8'h0F); tx_write(8'h0F);
        tx_q.push_back(8'h10); tx_write(8'h10);
        tx_write(8'h11);
        chk("buf_full_at_16", {31'h0, bus_if.io_buffer_full}, 32'h1);
        // push and pop together on a full FIFO
        uart_tx_ready = 1'b1;
        tx_q.push_back(8'h12); tx_write(8'h12);
        chk("buf_full_pushpop", {31'h0, bus_if.io_buffer_full}, 32'h1);
        repeat (24) cycle();
        chk("drain_done_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("drain_done_full",  {31'h0, bus_if.io_buffer_full}, 32'h0);
        chk("drain_done_queue", tx_q.size(), 32'h0);

        // RX holding
        uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
        cycle();
        uart_rx_valid = 1'b0;
        do_read(32'h30000, 8'h5A, "rx_first");
        do_read(32'h30000, 8'h00, "rx_cleared");
        uart_rx_data = 8'h21; uart_rx_valid = 1'b1;
        cycle();
        uart_rx_data = 8'h22;
        cycle();
        uart_rx_valid = 1'b0;
        do_read(32'h30000, 8'h22, "rx_overwrite");
        uart_rx_data = 8'h11; uart_rx_valid = 1'b1;
        do_read(32'h30000, 8'h00, "rx_same_cycle_old");
        uart_rx_valid = 1'b0;
        do_read(32'h30000, 8'h11, "rx_same_cycle_held");

        // counter snapshot
        repeat (300) cycle();
        snap = m_cnt;
        do_read(32'h30004, snap[7:0],   "cnt_b0");
        do_read(32'h30005, snap[15:8],  "cnt_b1");
        do_read(32'h30006, snap[23:16], "cnt_b2");
        do_read(32'h30007, snap[31:24], "cnt_b3");
        do_read(32'h30003, 8'h00,       "io_other_rd");

        // program stop
        tx_q.push_back(8'h00);
        do_write(32'h30004, 8'h99);
        chk("prog_stop_set", {31'h0, program_stop}, 32'h1);
        repeat (3) cycle();
        chk("stop_tx_empty", {31'h0, uart_tx_valid}, 32'h0);
        snap = m_cnt;
        do_read(32'h30004, snap[7:0], "cnt_frozen_a");
        repeat (10) cycle();
        do_read(32'h30004, snap[7:0], "cnt_frozen_b");
        do_read(32'h30005, snap[15:8], "cnt_frozen_b1");

        // reset during a drain
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_q.push_back(byte'(8'h61 + i));
            tx_write(byte'(8'h61 + i));
        end
        uart_tx_ready = 1'b1;
        repeat (2) cycle();
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("async_rst_tx_data",  {24'h0, uart_tx_data}, 32'h0);
        chk("async_rst_stop",     {31'h0, program_stop}, 32'h0);
        chk("async_rst_din",      {24'h0, bus_if.cpu_din}, 32'h0);
        tx_q.delete();
        cycle();
        rst_n_in = 1'b1;
        repeat (3) cycle();
        chk("post_rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        snap = m_cnt;
        do_read(32'h30004, snap[7:0], "cnt_after_rst");

        repeat (3) cycle();
        chk("end_rd_queue", rd_q.size(), 32'h0);
        chk("end_tx_queue", tx_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
